// File: rtl/serial_subtractor8.sv
// rtl/serial_subtractor8.sv - bit-serial subtractor d = x - y - b0 with start/ready/done handshake
// One shared full-subtractor cell walks the operands LSB first over WIDTH cycles.
module serial_subtractor8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b0,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out,
  output logic             v
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] x_sh;
  logic [WIDTH-1:0] y_sh;
  logic [WIDTH-1:0] d_sh;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             x_msb;
  logic             y_msb;

  logic             diff_bit;
  logic             br_next;
  logic [WIDTH-1:0] d_next;

  always_comb begin
    diff_bit = x_sh[0] ^ y_sh[0] ^ br;
    br_next  = (~x_sh[0] & y_sh[0]) | (~x_sh[0] & br) | (y_sh[0] & br);
    d_next   = {diff_bit, d_sh[WIDTH-1:1]};
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x_sh  <= '0;
      y_sh  <= '0;
      d_sh  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      x_msb <= 1'b0;
      y_msb <= 1'b0;
      d     <= '0;
      b_out <= 1'b0;
      v     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_sh  <= x;
            y_sh  <= y;
            br    <= b0;
            cnt   <= '0;
            x_msb <= x[WIDTH-1];
            y_msb <= y[WIDTH-1];
            state <= RUN;
          end
        end
        RUN: begin
          d_sh <= d_next;
          x_sh <= {1'b0, x_sh[WIDTH-1:1]};
          y_sh <= {1'b0, y_sh[WIDTH-1:1]};
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          // Results are published only here so they hold steady across the next operation.
          if (cnt == LAST) begin
            d     <= d_next;
            b_out <= br_next;
            v     <= (x_msb ^ y_msb) & (diff_bit ^ x_msb);
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor8.sv
// tb/tb_serial_subtractor8.sv - directed self-checking bench for serial_subtractor8
module tb_serial_subtractor8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x = 8'h00;
  logic [7:0] y = 8'h00;
  logic       b0 = 1'b0;
  logic       ready, busy, done, b_out, v;
  logic [7:0] d;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  serial_subtractor8 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .b0(b0),
    .ready(ready), .busy(busy), .done(done), .d(d), .b_out(b_out), .v(v)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  // Drives one operation and reports the result plus edges from accept to done.
  task automatic do_op(input logic [7:0] xa, input logic [7:0] ya, input logic ba,
                       output logic [7:0] od, output logic ob, output logic ov, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!ready && w < 20) begin @(negedge clk); w++; end
    x = xa; y = ya; b0 = ba; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; x = ~xa; y = 8'($urandom); b0 = ~ba;
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!done && lat < 20);
    od = d; ob = b_out; ov = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ready, busy, done} !== 3'b100) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 100", {ready, busy, done});
    end
    n_checks++;
    if ({d, b_out, v} !== 10'h000) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 000", {d, b_out, v});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] od; logic ob, ov; int lat;
    do_op(8'h5A, 8'h3C, 1'b0, od, ob, ov, lat);
    n_checks++;
    if (lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d expected 8", lat); end
    n_checks++;
    if ({od, ob, ov} !== {8'h1E, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL basic_result: got d=%h b=%b v=%b expected d=1e b=0 v=0", od, ob, ov);
    end
    @(negedge clk);
    n_checks++;
    if ({done, ready} !== 2'b01) begin
      n_fail++; $display("FAIL done_one_cycle: got done,ready=%b expected 01", {done, ready});
    end
  endtask

  task automatic test_borrow();
    logic [7:0] od; logic ob, ov; int lat;
    do_op(8'h00, 8'h01, 1'b0, od, ob, ov, lat);
    n_checks++;
    if ({od, ob, ov} !== {8'hFF, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL borrow_out: got d=%h b=%b v=%b expected d=ff b=1 v=0", od, ob, ov);
    end
    do_op(8'h80, 8'h01, 1'b0, od, ob, ov, lat);
    n_checks++;
    if ({od, ob, ov} !== {8'h7F, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL overflow: got d=%h b=%b v=%b expected d=7f b=0 v=1", od, ob, ov);
    end
  endtask

  task automatic test_borrow_in();
    logic [7:0] od; logic ob, ov; int lat;
    do_op(8'h10, 8'h0F, 1'b1, od, ob, ov, lat);
    n_checks++;
    if ({od, ob, ov} !== {8'h00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL borrow_in_zero: got d=%h b=%b v=%b expected d=00 b=0 v=0", od, ob, ov);
    end
    do_op(8'h00, 8'hFF, 1'b1, od, ob, ov, lat);
    n_checks++;
    if ({od, ob, ov} !== {8'h00, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL borrow_in_wrap: got d=%h b=%b v=%b expected d=00 b=1 v=0", od, ob, ov);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] px [4];
    logic [7:0] py [4];
    logic       pb [4];
    logic [9:0] pe [4];
    int acc [4];
    int na, nd, t;
    px = '{8'h33, 8'h7F, 8'hC8, 8'hFF};
    py = '{8'h11, 8'hFF, 8'h64, 8'hFF};
    pb = '{1'b0, 1'b0, 1'b1, 1'b1};
    pe = '{{8'h22, 2'b00}, {8'h80, 2'b11}, {8'h63, 2'b01}, {8'hFF, 2'b10}};
    na = 0; nd = 0; t = 0;
    @(negedge clk);
    start = 1'b1;
    while (nd < 4 && t < 80) begin
      if (done) begin
        n_checks++;
        if ({d, b_out, v} !== pe[nd]) begin
          n_fail++; $display("FAIL b2b_result%0d: got %h expected %h", nd, {d, b_out, v}, pe[nd]);
        end
        nd++;
      end
      if (ready && na < 4) begin
        x = px[na]; y = py[na]; b0 = pb[na]; acc[na] = cyc; na++;
      end else if (ready) begin
        start = 1'b0;
      end else begin
        x = 8'($urandom); y = 8'($urandom); b0 = 1'($urandom);
      end
      @(negedge clk); t++;
    end
    start = 1'b0;
    n_checks++;
    if (nd !== 4) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 4", nd); end
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (acc[i] - acc[i-1] !== 10) begin
        n_fail++; $display("FAIL b2b_spacing%0d: got %0d expected 10", i, acc[i] - acc[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] od; logic ob, ov; int lat; logic saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    x = 8'hAA; y = 8'h55; b0 = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ready, busy, done, d, b_out, v} !== 13'h1000) begin
      n_fail++;
      $display("FAIL mid_run_reset: got r=%b bz=%b dn=%b d=%h b=%b v=%b expected r=1 bz=0 dn=0 d=00 b=0 v=0",
               ready, busy, done, d, b_out, v);
    end
    repeat (2) begin @(negedge clk); saw_done |= done; end
    rst_n = 1'b1;
    repeat (12) begin @(negedge clk); saw_done |= done; end
    n_checks++;
    if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got 1 expected 0"); end
    do_op(8'hAA, 8'h55, 1'b0, od, ob, ov, lat);
    n_checks++;
    if ({od, ob, ov, lat} !== {8'h55, 1'b1 ^ 1'b1, 1'b1, 32'd8}) begin
      n_fail++; $display("FAIL after_reset_op: got d=%h b=%b v=%b lat=%0d expected d=55 b=0 v=1 lat=8",
                         od, ob, ov, lat);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] vals [9];
    logic [7:0] od; logic ob, ov; int lat;
    logic [8:0] diff;
    logic [9:0] exp_r;
    vals = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF, 8'h5A};
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 9; j++) begin
        for (int b = 0; b < 2; b++) begin
          do_op(vals[i], vals[j], 1'(b), od, ob, ov, lat);
          diff = {1'b0, vals[i]} - {1'b0, vals[j]} - 9'(b);
          exp_r = {diff[7:0], diff[8], (vals[i][7] != vals[j][7]) && (diff[7] != vals[i][7])};
          n_checks++;
          if ({od, ob, ov} !== exp_r) begin
            n_fail++;
            $display("FAIL sweep x=%h y=%h b0=%0d: got %h expected %h", vals[i], vals[j], b, {od, ob, ov}, exp_r);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_borrow_in();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
